// File: rtl/vga_pll_lock_sequencer.sv
// Supervises the VGA pixel-clock PLL: pulses its reset, waits for lock with timeout
// and bounded retries, qualifies lock stability, then releases the video-pipeline reset.
module vga_pll_lock_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       video_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [2:0] retry_cnt,
  output logic [2:0] state_dbg
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ALL = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
  localparam int CW      = $clog2(MAX_ALL);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    retry_next;
  logic          lost_next;
  logic [1:0]    sync_q;
  logic          locked_s;

  assign locked_s  = sync_q[1];
  assign state_dbg = state;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    retry_next = retry_cnt;
    lost_next  = lock_lost;
    case (state)
      S_PLL_RESET: begin
        cnt_next = cnt + 1'b1;
        if (cnt == CW'(PLL_RST_CYCLES - 1)) next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock wins over a coincident timeout.
        if (locked_s) begin
          next_state = S_STABILIZE;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
            if (retry_cnt == 3'(MAX_RETRIES)) begin
              next_state = S_FAIL;
            end else begin
              retry_next = retry_cnt + 3'd1;
              next_state = S_PLL_RESET;
            end
          end
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
        end else begin
          cnt_next = cnt + 1'b1;
          if (cnt == CW'(LOCK_STABLE - 1)) begin
            next_state = S_RUN;
            retry_next = 3'd0;
          end
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          lost_next  = 1'b1;
          retry_next = 3'd0;
          next_state = S_PLL_RESET;
        end
      end
      S_FAIL: begin
        next_state = S_FAIL;
      end
      default: begin
        next_state = S_PLL_RESET;
      end
    endcase
    if (restart) begin
      next_state = S_PLL_RESET;
      retry_next = 3'd0;
      lost_next  = 1'b0;
    end
    // The counter restarts on every state change, and on a restart that stays in PLL_RESET.
    if (restart || (next_state != state)) cnt_next = '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLL_RESET;
      cnt       <= '0;
      sync_q    <= 2'b00;
      retry_cnt <= 3'd0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      video_rst <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= next_state;
      cnt       <= cnt_next;
      sync_q    <= {sync_q[0], pll_locked};
      retry_cnt <= retry_next;
      lock_lost <= lost_next;
      // Outputs decode the next state so they move on the same edge as the state.
      pll_rst   <= (next_state == S_PLL_RESET) || (next_state == S_FAIL);
      video_rst <= (next_state != S_RUN);
      ready     <= (next_state == S_RUN);
      fail      <= (next_state == S_FAIL);
    end
  end

endmodule

// File: tb/tb_vga_pll_lock_sequencer.sv
// Bench for vga_pll_lock_sequencer: directed scenarios plus random lock/restart/reset
// traffic, checked every cycle against a phase/elapsed-time reference model.
module tb_vga_pll_lock_sequencer;

  localparam int PRC = 4;
  localparam int LT  = 20;
  localparam int LS  = 8;
  localparam int MR  = 2;

  localparam int P_RESET = 0;
  localparam int P_WAIT  = 1;
  localparam int P_STAB  = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAIL  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       restart = 1'b0;
  logic       pll_rst, video_rst, ready, fail, lock_lost;
  logic [2:0] retry_cnt, state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  vga_pll_lock_sequencer #(
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT(LT),
    .LOCK_STABLE(LS),
    .MAX_RETRIES(MR)
  ) dut (
    .refclk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .restart(restart),
    .pll_rst(pll_rst),
    .video_rst(video_rst),
    .ready(ready),
    .fail(fail),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference model: which phase we are in and how long we have been there.
  int m_phase = P_RESET;
  int m_elapsed = 0;
  int m_retries = 0;
  bit m_lost = 1'b0;
  logic [1:0] lk_hist = 2'b00;  // lock samples taken one and two edges ago

  always @(posedge clk) begin
    bit ls;
    ls = lk_hist[1];
    if (rst) begin
      m_phase = P_RESET; m_elapsed = 0; m_retries = 0; m_lost = 1'b0;
      lk_hist = 2'b00;
    end else begin
      lk_hist = {lk_hist[0], pll_locked};
      if (restart) begin
        m_phase = P_RESET; m_elapsed = 0; m_retries = 0; m_lost = 1'b0;
      end else begin
        case (m_phase)
          P_RESET: begin
            m_elapsed++;
            if (m_elapsed == PRC) begin m_phase = P_WAIT; m_elapsed = 0; end
          end
          P_WAIT: begin
            if (ls) begin
              m_phase = P_STAB; m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == LT) begin
                m_elapsed = 0;
                if (m_retries == MR) m_phase = P_FAIL;
                else begin m_retries++; m_phase = P_RESET; end
              end
            end
          end
          P_STAB: begin
            if (!ls) begin
              m_phase = P_WAIT; m_elapsed = 0;
            end else begin
              m_elapsed++;
              if (m_elapsed == LS) begin m_phase = P_RUN; m_elapsed = 0; m_retries = 0; end
            end
          end
          P_RUN: begin
            if (!ls) begin m_phase = P_RESET; m_elapsed = 0; m_retries = 0; m_lost = 1'b1; end
          end
          default: ;
        endcase
      end
    end
  end

  // scoreboard: every cycle, away from the active edge
  always @(negedge clk) begin
    check("state_dbg", int'(state_dbg), m_phase);
    check("pll_rst", int'(pll_rst), int'(m_phase == P_RESET || m_phase == P_FAIL));
    check("video_rst", int'(video_rst), int'(m_phase != P_RUN));
    check("ready", int'(ready), int'(m_phase == P_RUN));
    check("fail", int'(fail), int'(m_phase == P_FAIL));
    check("lock_lost", int'(lock_lost), int'(m_lost));
    check("retry_cnt", int'(retry_cnt), m_retries);
  end

  // driver tasks (inputs change on the falling edge)
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input int s, input int budget);
    int n = 0;
    while (int'(state_dbg) != s && n < budget) begin @(posedge clk); #1; n++; end
    if (int'(state_dbg) != s) check({tag, "_timeout"}, int'(state_dbg), s);
    @(negedge clk);
  endtask

  // Edges counted from a falling-edge input change until 'ready' reaches 'lvl'.
  task automatic edges_to_ready(input logic lvl, output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ready != lvl && n < 100);
  endtask

  task automatic pulse_restart();
    restart = 1'b1; step(1); restart = 1'b0;
  endtask

  int n;
  int rst_seen;

  initial begin
    // 1. nominal lock
    step(3);
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (pll_rst && n < 50);
    check("pll_rst_pulse_len", n, PRC);
    @(negedge clk);
    step(10 - n);
    pll_locked = 1'b1;
    edges_to_ready(1'b1, n);
    // two synchroniser stages, one decision edge, then LS stable cycles
    check("lock_to_ready", n, 3 + LS);
    check("nominal_retry", int'(retry_cnt), 0);
    check("nominal_state", int'(state_dbg), P_RUN);
    @(negedge clk);

    // 2. glitch during STABILIZE
    pll_locked = 1'b0;
    wait_state("glitch_relost", P_RESET, 20);
    pll_locked = 1'b1;
    wait_state("glitch_stab", P_STAB, 40);
    step(5);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    rst_seen = 0;
    n = 0;
    do begin @(posedge clk); #1; n++; if (pll_rst) rst_seen++; end while (!ready && n < 100);
    check("glitch_to_ready", n, 3 + LS);
    check("glitch_no_pll_rst", rst_seen, 0);
    @(negedge clk);

    // 4. loss of lock in RUN
    pll_locked = 1'b0;
    edges_to_ready(1'b0, n);
    check("loss_to_ready_low", n, 3);
    check("loss_lock_lost", int'(lock_lost), 1);
    @(negedge clk);
    step(8);
    pll_locked = 1'b1;
    wait_state("relock_run", P_RUN, 100);
    check("relock_lock_lost", int'(lock_lost), 1);

    // 3. timeout to FAIL
    pll_locked = 1'b0;
    wait_state("to_fail", P_FAIL, 3 * (PRC + LT) + 40);
    step(5);
    check("fail_hold", int'(fail), 1);

    // 5. restart from FAIL
    pulse_restart();
    check("restart_state", int'(state_dbg), P_RESET);
    check("restart_fail", int'(fail), 0);
    pll_locked = 1'b1;
    wait_state("restart_run", P_RUN, 100);

    // 6. rst during STABILIZE
    pll_locked = 1'b0;
    wait_state("r6_reset", P_RESET, 20);
    pll_locked = 1'b1;
    wait_state("r6_stab", P_STAB, 40);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (pll_rst && n < 50);
    check("r6_pll_rst_len", n, PRC);
    @(negedge clk);

    // random traffic
    for (int k = 0; k < 150; k++) begin
      pll_locked = ($urandom_range(0, 3) != 0);
      for (int j = 0, len = $urandom_range(1, 30); j < len; j++) begin
        if ($urandom_range(0, 99) == 0) restart = 1'b1;
        if ($urandom_range(0, 399) == 0) rst = 1'b1;
        step(1);
        restart = 1'b0;
        rst = 1'b0;
      end
    end

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
